// File: rtl/perceptron_pkg.sv
// Shared widths, FSM encoding, weight type and saturating +/-1 step for the perceptron predictor.
// Pure declarations: no latency, no flow control.
package perceptron_pkg;

  localparam int MAX_WBITS = 10;

  typedef logic signed [MAX_WBITS-1:0] weight_t;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    UPD  = 2'd2
  } bp_state_t;

  // Wide enough for (HIST+1) * 2^(WBITS-1) in magnitude, so no overflow.
  function automatic int sum_width(input int wbits, input int hist);
    return wbits + $clog2(hist + 2);
  endfunction

  function automatic int idx_width(input int entries);
    return $clog2(entries);
  endfunction

  function automatic weight_t sat_step(input weight_t w, input logic inc, input int wbits);
    int v;
    int hi;
    int lo;
    v  = int'(w);
    hi = (1 << (wbits - 1)) - 1;
    lo = -(1 << (wbits - 1));
    if (inc) begin
      if (v < hi) v = v + 1;
    end else if (v > lo) begin
      v = v - 1;
    end
    return weight_t'(v);
  endfunction

endpackage

// File: rtl/perceptron_sum.sv
// Combinational signed sum of the optional bias plus HIST GHR-signed weights; no state, no flow control.
module perceptron_sum #(
  parameter int HIST  = 12,
  parameter int WBITS = 8,
  parameter int NB    = 1,
  parameter int SW    = 12
) (
  input  logic [(HIST+NB)*WBITS-1:0] weights,
  input  logic [HIST-1:0]            ghr,
  output logic signed [SW-1:0]       sum
);

  localparam int NW = HIST + NB;

  logic signed [SW-1:0] ext;
  int                   gi;

  always_comb begin
    sum = '0;
    ext = '0;
    gi  = 0;
    for (int k = 0; k < NW; k++) begin
      ext = {{(SW-WBITS){weights[k*WBITS+WBITS-1]}}, weights[k*WBITS +: WBITS]};
      gi  = (k >= NB) ? k - NB : 0;
      // Bias (k < NB) is always added; history weights follow the GHR bit sign.
      if (k >= NB && !ghr[gi]) sum = sum - ext;
      else                     sum = sum + ext;
    end
  end

endmodule

// File: rtl/perceptron_bpred.sv
// Perceptron branch predictor: lookup result 1 cycle after accept; updates take 2 cycles (up_ready low in UPD/INIT).
// PERCEPTRON_BIAS_EN adds a stored, summed and trained bias weight w0 to each row.
module perceptron_bpred
  import perceptron_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int HIST    = 12,
  parameter int WBITS   = 8,
  parameter int THETA   = 37,
  parameter int SW      = sum_width(WBITS, HIST)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lu_valid,
  input  logic [31:0]          lu_pc,
  output logic                 lu_ready,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic signed [SW-1:0] pred_sum,
  output logic [HIST-1:0]      pred_ghr,
  input  logic                 up_valid,
  input  logic [31:0]          up_pc,
  input  logic [HIST-1:0]      up_ghr,
  input  logic signed [SW-1:0] up_sum,
  input  logic                 up_taken,
  input  logic                 up_mispred,
  output logic                 up_ready
);

`ifdef PERCEPTRON_BIAS_EN
  localparam int NB = 1;
`else
  localparam int NB = 0;
`endif
  localparam int NW = HIST + NB;
  localparam int IW = idx_width(ENTRIES);
  localparam int RW = NW * WBITS;

  logic [RW-1:0]        mem [ENTRIES];
  bp_state_t            state;
  bp_state_t            state_nxt;
  logic [IW-1:0]        sweep_cnt;
  logic [HIST-1:0]      spec_ghr;
  logic [RW-1:0]        lu_row_q;
  logic [RW-1:0]        up_row_q;
  logic [HIST-1:0]      up_ghr_q;
  logic                 up_taken_q;
  logic [IW-1:0]        up_idx_q;
  logic [RW-1:0]        new_row;
  logic [RW-1:0]        wr_data;
  logic [IW-1:0]        wr_idx;
  logic                 wr_en;
  logic                 lu_acc;
  logic                 up_acc;
  logic                 up_train;
  logic signed [SW:0]   up_sum_ext;
  logic signed [SW:0]   up_abs;
  logic signed [SW-1:0] sum;
  weight_t              w_old;
  weight_t              w_new;
  logic                 inc;
  int                   gi;
  logic                 unused_pc_bits;

  assign unused_pc_bits = ^{lu_pc[31:IW+2], lu_pc[1:0], up_pc[31:IW+2], up_pc[1:0]};

  assign lu_acc     = lu_valid & lu_ready;
  assign up_acc     = up_valid & up_ready;
  // Extra bit so that |most-negative sum| cannot wrap.
  assign up_sum_ext = {up_sum[SW-1], up_sum};
  assign up_abs     = up_sum_ext[SW] ? -up_sum_ext : up_sum_ext;
  assign up_train   = up_mispred || (up_abs <= (SW+1)'(THETA));

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (sweep_cnt == IW'(ENTRIES - 1)) state_nxt = IDLE;
      IDLE:    if (up_acc && up_train) state_nxt = UPD;
      UPD:     state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // A reset arriving in INIT or UPD suppresses the write at that edge.
  always_comb begin
    lu_ready = 1'b0;
    up_ready = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = sweep_cnt;
    wr_data  = '0;
    case (state)
      INIT: wr_en = !reset;
      IDLE: begin
        lu_ready = 1'b1;
        up_ready = 1'b1;
      end
      UPD: begin
        lu_ready = 1'b1;
        wr_en    = !reset;
        wr_idx   = up_idx_q;
        wr_data  = new_row;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)              sweep_cnt <= '0;
    else if (state == INIT) sweep_cnt <= sweep_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid <= 1'b0;
      lu_row_q   <= '0;
      pred_ghr   <= '0;
    end else begin
      pred_valid <= lu_acc;
      if (lu_acc) begin
        lu_row_q <= mem[lu_pc[IW+1:2]];
        pred_ghr <= spec_ghr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (up_acc && up_train) begin
      up_row_q   <= mem[up_pc[IW+1:2]];
      up_ghr_q   <= up_ghr;
      up_taken_q <= up_taken;
      up_idx_q   <= up_pc[IW+1:2];
    end
  end

  always_comb begin
    new_row = up_row_q;
    w_old   = '0;
    w_new   = '0;
    inc     = 1'b0;
    gi      = 0;
    for (int k = 0; k < NW; k++) begin
      gi    = (k >= NB) ? k - NB : 0;
      w_old = weight_t'($signed(up_row_q[k*WBITS +: WBITS]));
      inc   = (k < NB) ? up_taken_q : (up_taken_q == up_ghr_q[gi]);
      w_new = sat_step(w_old, inc, WBITS);
      new_row[k*WBITS +: WBITS] = w_new[WBITS-1:0];
    end
  end

  // Misprediction recovery wins over the speculative shift of the same cycle.
  always_ff @(posedge clk) begin
    if (reset)                     spec_ghr <= '0;
    else if (up_acc && up_mispred) spec_ghr <= {up_ghr[HIST-2:0], up_taken};
    else if (pred_valid)           spec_ghr <= {spec_ghr[HIST-2:0], pred_taken};
  end

  perceptron_sum #(
    .HIST  (HIST),
    .WBITS (WBITS),
    .NB    (NB),
    .SW    (SW)
  ) u_sum (
    .weights (lu_row_q),
    .ghr     (pred_ghr),
    .sum     (sum)
  );

  assign pred_sum   = sum;
  assign pred_taken = pred_valid & ~sum[SW-1];

endmodule

// File: tb/tb_perceptron_bpred.sv
// Scoreboard bench for perceptron_bpred: expected predictions queued at lookup, checked when pred_valid rises.
`timescale 1ns/1ps
module tb_perceptron_bpred;
  import perceptron_pkg::*;

  localparam int ENTRIES = 64;
  localparam int HIST    = 12;
  localparam int WBITS   = 8;
  localparam int THETA   = 37;
  localparam int SW      = sum_width(WBITS, HIST);
  localparam int IW      = $clog2(ENTRIES);
`ifdef PERCEPTRON_BIAS_EN
  localparam int NB = 1;
`else
  localparam int NB = 0;
`endif
  localparam int NW   = HIST + NB;
  localparam int WMAX = (1 << (WBITS - 1)) - 1;
  localparam int WMIN = -(1 << (WBITS - 1));
  localparam logic [HIST-1:0] ONES = '1;

  typedef struct {
    int              sum;
    logic            taken;
    logic [HIST-1:0] ghr;
  } exp_t;

  logic                 clk;
  logic                 reset;
  logic                 lu_valid;
  logic [31:0]          lu_pc;
  logic                 lu_ready;
  logic                 pred_valid;
  logic                 pred_taken;
  logic signed [SW-1:0] pred_sum;
  logic [HIST-1:0]      pred_ghr;
  logic                 up_valid;
  logic [31:0]          up_pc;
  logic [HIST-1:0]      up_ghr;
  logic signed [SW-1:0] up_sum;
  logic                 up_taken;
  logic                 up_mispred;
  logic                 up_ready;

  perceptron_bpred #(
    .ENTRIES (ENTRIES),
    .HIST    (HIST),
    .WBITS   (WBITS),
    .THETA   (THETA)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .lu_valid   (lu_valid),
    .lu_pc      (lu_pc),
    .lu_ready   (lu_ready),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_sum   (pred_sum),
    .pred_ghr   (pred_ghr),
    .up_valid   (up_valid),
    .up_pc      (up_pc),
    .up_ghr     (up_ghr),
    .up_sum     (up_sum),
    .up_taken   (up_taken),
    .up_mispred (up_mispred),
    .up_ready   (up_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int              n_vec = 0;
  int              n_err = 0;
  exp_t            sb[$];
  exp_t            mon_e;
  int              mw [ENTRIES][HIST+1];
  logic [HIST-1:0] m_ghr;
  longint          last_sum;
  logic [HIST-1:0] last_ghr;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int row_of(input logic [31:0] pc);
    return int'(pc[IW+1:2]);
  endfunction

  function automatic int clampw(input int v);
    if (v > WMAX) return WMAX;
    if (v < WMIN) return WMIN;
    return v;
  endfunction

  function automatic int m_sum(input int r, input logic [HIST-1:0] g);
    int s;
    s = (NB == 1) ? mw[r][0] : 0;
    for (int i = 1; i <= HIST; i++) s += g[i-1] ? mw[r][i] : -mw[r][i];
    return s;
  endfunction

  task automatic m_train(input int r, input logic [HIST-1:0] g, input logic t,
                         input logic mis, input int s);
    if (!(mis || (s <= THETA && s >= -THETA))) return;
    if (NB == 1) mw[r][0] = clampw(mw[r][0] + (t ? 1 : -1));
    for (int i = 1; i <= HIST; i++)
      mw[r][i] = clampw(mw[r][i] + ((t == g[i-1]) ? 1 : -1));
  endtask

  task automatic m_clear();
    for (int r = 0; r < ENTRIES; r++)
      for (int i = 0; i <= HIST; i++) mw[r][i] = 0;
    m_ghr = '0;
  endtask

  task automatic wait_sweep();
    int n;
    n = 0;
    while (!lu_ready && n < 1000) begin
      n++;
      tick();
    end
    check("init_cycles", n, ENTRIES);
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.sum   = m_sum(row_of(pc), m_ghr);
    e.taken = (e.sum >= 0);
    e.ghr   = m_ghr;
    sb.push_back(e);
    m_ghr = {m_ghr[HIST-2:0], e.taken};
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    push_exp(pc);
    lu_valid = 1'b1;
    lu_pc    = pc;
    tick();
    lu_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [HIST-1:0] g, input int s,
                           input logic t, input logic mis);
    int n;
    n = 0;
    while (!up_ready && n < 50) begin
      n++;
      tick();
    end
    check("up_ready_wait", up_ready, 1);
    up_valid   = 1'b1;
    up_pc      = pc;
    up_ghr     = g;
    up_sum     = SW'(s);
    up_taken   = t;
    up_mispred = mis;
    tick();
    up_valid = 1'b0;
    m_train(row_of(pc), g, t, mis, s);
    if (mis) m_ghr = {g[HIST-2:0], t};
    tick();
  endtask

  always @(negedge clk) begin
    if (pred_valid) begin
      if (sb.size() == 0) begin
        check("spurious_pred", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pred_sum", pred_sum, mon_e.sum);
        check("pred_taken", pred_taken, mon_e.taken);
        check("pred_ghr", pred_ghr, mon_e.ghr);
        last_sum = pred_sum;
        last_ghr = pred_ghr;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_vec %0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HIST-1:0] g;
    logic [HIST-1:0] gexp;
    int              s;

    reset = 1'b1; lu_valid = 1'b0; lu_pc = '0; up_valid = 1'b0; up_pc = '0;
    up_ghr = '0; up_sum = '0; up_taken = 1'b0; up_mispred = 1'b0;
    m_clear();
    tick();
    check("rst_lu_ready", lu_ready, 0);
    check("rst_up_ready", up_ready, 0);
    check("rst_pred_valid", pred_valid, 0);
    check("rst_pred_taken", pred_taken, 0);
    check("rst_pred_sum", pred_sum, 0);
    check("rst_pred_ghr", pred_ghr, 0);
    tick();
    reset = 1'b0;
    wait_sweep();

    // Fresh table: zero sum predicts taken.
    do_lookup(32'h0000_0000);
    check("first_sum", last_sum, 0);

    // Five mispredicted taken updates with all-ones history.
    for (int i = 0; i < 5; i++) do_update(32'h40, ONES, 0, 1'b1, 1'b1);
    do_lookup(32'h40);
    check("train5_sum", last_sum, 5 * NW);

    // Threshold: |sum| above THETA without mispredict is discarded.
    do_update(32'h40, ONES, 40, 1'b1, 1'b0);
    do_lookup(32'h40);
    check("theta40_nowrite", last_sum, 5 * NW);
    do_update(32'h40, ONES, THETA, 1'b1, 1'b0);
    do_lookup(32'h40);
    check("theta37_write", last_sum, 6 * NW);
    do_update(32'h40, ONES, -38, 1'b0, 1'b0);
    do_lookup(32'h40);
    do_update(32'h40, ONES, -THETA, 1'b0, 1'b0);
    do_lookup(32'h40);

    // Recovery and speculative shift in the same cycle: recovery wins.
    g = 12'hA5C;
    push_exp(32'h40);
    lu_valid = 1'b1;
    lu_pc    = 32'h40;
    tick();
    lu_valid   = 1'b0;
    check("collide_pred_valid", pred_valid, 1);
    up_valid   = 1'b1;
    up_pc      = 32'h200;
    up_ghr     = g;
    up_sum     = '0;
    up_taken   = 1'b0;
    up_mispred = 1'b1;
    tick();
    up_valid = 1'b0;
    m_train(row_of(32'h200), g, 1'b0, 1'b1, 0);
    gexp  = {g[HIST-2:0], 1'b0};
    m_ghr = gexp;
    tick();
    tick();
    do_lookup(32'h200);
    check("ghr_recovery_prio", last_ghr, gexp);

    // Saturation: 200 taken updates on one row.
    for (int i = 0; i < 200; i++) do_update(32'h80, ONES, 0, 1'b1, 1'b1);
    do_lookup(32'h80);
    check("sat_sum", last_sum, NW * WMAX);

    // Mixed random traffic over a few rows.
    for (int i = 0; i < 24; i++) begin
      g = HIST'($urandom);
      s = int'($urandom_range(0, 100)) - 50;
      do_update(32'h100 + 32'($urandom_range(0, 3) * 4), g, s,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      do_lookup(32'h100 + 32'($urandom_range(0, 3) * 4));
    end

    // Reset in UPD for row 5 drops the write and resweeps the table.
    do_update(32'h14, ONES, 0, 1'b1, 1'b1);
    up_valid   = 1'b1;
    up_pc      = 32'h14;
    up_ghr     = ONES;
    up_sum     = '0;
    up_taken   = 1'b1;
    up_mispred = 1'b1;
    tick();
    up_valid = 1'b0;
    check("upd_busy", up_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_clear();
    wait_sweep();
    do_lookup(32'h14);
    check("row5_cleared", last_sum, 0);
    do_lookup(32'h80);
    check("row32_cleared", last_sum, 0);

    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
